id_decode_pipe: RTL and testbench

- Registered instruction-decode stage for the MIPS core, placed between the IF/ID register and the ID/EX path.
- Decodes the incoming instruction into the control bundle, flags reserved instructions, and marks branch/jump delay-slot instructions.
- Buffers decoded results in a 2-entry skid buffer with valid/ready handshakes, flush and backpressure.
- Generalises the combinational main decoder: parametrised ALU-op width, load/store decode, registered outputs.

---
 rtl/id_decode_pipe_pkg.sv | 36 +++
 rtl/id_decode_pipe_if.sv | 18 +
 rtl/id_decode_pipe_ctrl_decode_comb.sv | 75 +++++++
 rtl/id_decode_pipe.sv | 68 ++++++
 tb/tb_id_decode_pipe.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/id_decode_pipe_pkg.sv
// id_decode_pipe_pkg: opcodes, ALU op codes, out_ctrl field layout and delay-slot states for the ID stage.
package id_decode_pipe_pkg;
  localparam int ALUOP_W_DEF = 5;
  localparam int CTRL_W_DEF = 12 + ALUOP_W_DEF;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J = 6'h02, OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04, F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2a, F_SLTU = 6'h2b;
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10, RT_BGEZAL = 5'h11;
  localparam logic [ALUOP_W_DEF-1:0] NOP_OP = 5'd0, R_OP = 5'd1, ADDI_OP = 5'd2, ADDIU_OP = 5'd3;
  localparam logic [ALUOP_W_DEF-1:0] SLTI_OP = 5'd4, SLTIU_OP = 5'd5, ANDI_OP = 5'd6, ORI_OP = 5'd7;
  localparam logic [ALUOP_W_DEF-1:0] XORI_OP = 5'd8, LUI_OP = 5'd9;
  // memen is bit 0 and aluop starts at bit 1; the one-bit flags sit above aluop at these offsets.
  localparam int MEMEN_B = 0, ALUOP_LSB = 1;
  localparam int JALR_O = 0, BAL_O = 1, JR_O = 2, JAL_O = 3, JUMP_O = 4, MEMTOREG_O = 5;
  localparam int MEMWRITE_O = 6, BRANCH_O = 7, ALUSRC_O = 8, REGDST_O = 9, REGWRITE_O = 10;
  typedef enum logic {DS_NORMAL, DS_SLOT} ds_state_e;
  function automatic logic [ALUOP_W_DEF-1:0] imm_aluop(logic [5:0] op);
    case (op)
      OP_ADDI: return ADDI_OP;
      OP_ADDIU: return ADDIU_OP;
      OP_SLTI: return SLTI_OP;
      OP_SLTIU: return SLTIU_OP;
      OP_ANDI: return ANDI_OP;
      OP_ORI: return ORI_OP;
      OP_XORI: return XORI_OP;
      default: return LUI_OP;
    endcase
  endfunction
endpackage

// File: rtl/id_decode_pipe_if.sv
// id_decode_pipe_if: IF/ID-to-decode and decode-to-EX handshakes plus pipeline flush.
interface id_decode_pipe_if import id_decode_pipe_pkg::*; #(
  parameter int PC_W = 32,
  parameter int ALUOP_W = ALUOP_W_DEF
);
  logic flush, in_valid, in_ready, out_valid, out_ready, out_ri, out_in_ds;
  logic [31:0] in_instr, out_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [12+ALUOP_W-1:0] out_ctrl;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input in_ready, out_valid, out_pc, out_instr, out_ctrl, out_ri, out_in_ds
  );
  modport slave (
    input flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_ctrl, out_ri, out_in_ds
  );
endinterface

// File: rtl/id_decode_pipe_ctrl_decode_comb.sv
// id_decode_pipe_ctrl_decode_comb: main decoder from instruction word to control bundle, RI flag and CTI flag.
module id_decode_pipe_ctrl_decode_comb import id_decode_pipe_pkg::*; #(
  parameter int ALUOP_W = ALUOP_W_DEF
) (
  input  logic [31:0] instr,
  output logic [12+ALUOP_W-1:0] ctrl,
  output logic ri,
  output logic is_cti
);
  localparam int F = ALUOP_W + 1;
  logic [5:0] op, fn;
  logic [4:0] rt;
  logic unused_bits;
  assign op = instr[31:26];
  assign rt = instr[20:16];
  assign fn = instr[5:0];
  assign unused_bits = ^{instr[25:21], instr[15:6]};
  always_comb begin
    ctrl = '0;
    ri = 1'b0;
    case (op)
      OP_RTYPE:
        case (fn)
          F_JR: ctrl[F+JR_O] = 1'b1;
          F_JALR: begin
            ctrl[F+REGWRITE_O] = 1'b1;
            ctrl[F+JALR_O] = 1'b1;
          end
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            ctrl[F+REGWRITE_O] = 1'b1;
            ctrl[F+REGDST_O] = 1'b1;
            ctrl[ALUOP_W:ALUOP_LSB] = ALUOP_W'(R_OP);
          end
          default: ri = 1'b1;
        endcase
      OP_REGIMM:
        case (rt)
          RT_BLTZ, RT_BGEZ: ctrl[F+BRANCH_O] = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin
            ctrl[F+BRANCH_O] = 1'b1;
            ctrl[F+REGWRITE_O] = 1'b1;
            ctrl[F+BAL_O] = 1'b1;
          end
          default: ri = 1'b1;
        endcase
      OP_J: ctrl[F+JUMP_O] = 1'b1;
      OP_JAL: begin
        ctrl[F+REGWRITE_O] = 1'b1;
        ctrl[F+JAL_O] = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ctrl[F+BRANCH_O] = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl[F+REGWRITE_O] = 1'b1;
        ctrl[F+ALUSRC_O] = 1'b1;
        ctrl[ALUOP_W:ALUOP_LSB] = ALUOP_W'(imm_aluop(op));
      end
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: begin
        ctrl[F+REGWRITE_O] = 1'b1;
        ctrl[F+ALUSRC_O] = 1'b1;
        ctrl[F+MEMTOREG_O] = 1'b1;
        ctrl[MEMEN_B] = 1'b1;
        ctrl[ALUOP_W:ALUOP_LSB] = ALUOP_W'(ADDIU_OP);
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl[F+ALUSRC_O] = 1'b1;
        ctrl[F+MEMWRITE_O] = 1'b1;
        ctrl[MEMEN_B] = 1'b1;
        ctrl[ALUOP_W:ALUOP_LSB] = ALUOP_W'(ADDIU_OP);
      end
      default: ri = 1'b1;
    endcase
  end
  assign is_cti = |{ctrl[F+BRANCH_O], ctrl[F+JUMP_O], ctrl[F+JAL_O], ctrl[F+JR_O], ctrl[F+JALR_O], ctrl[F+BAL_O]};
endmodule

// File: rtl/id_decode_pipe.sv
// id_decode_pipe: registered ID stage; decodes into a skid buffer and tags branch delay-slot entries.
module id_decode_pipe import id_decode_pipe_pkg::*; #(
  parameter int ALUOP_W = ALUOP_W_DEF,
  parameter int PC_W = 32,
  parameter int BUF_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  id_decode_pipe_if.slave bus
);
  localparam int CTRL_W = 12 + ALUOP_W;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0] instr;
    logic [CTRL_W-1:0] ctrl;
    logic ri;
    logic ds;
  } entry_t;
  entry_t ent_q [BUF_DEPTH];
  entry_t ent_d [BUF_DEPTH];
  logic [CNT_W-1:0] count_q, count_d, widx;
  logic in_ready_q, in_ready_d, push, pop, dec_ri, dec_cti;
  logic [CTRL_W-1:0] dec_ctrl;
  ds_state_e ds_q, ds_d;
  id_decode_pipe_ctrl_decode_comb #(.ALUOP_W(ALUOP_W)) u_dec (
    .instr(bus.in_instr),
    .ctrl(dec_ctrl),
    .ri(dec_ri),
    .is_cti(dec_cti)
  );
  // Slot 0 is always the head; a pop shifts the rest down and a push lands just behind the survivors.
  always_comb begin
    push = bus.in_valid && in_ready_q && !bus.flush;
    pop = (count_q != '0) && bus.out_ready;
    widx = count_q - CNT_W'(pop);
    ent_d = ent_q;
    for (int i = 0; i < BUF_DEPTH - 1; i++) ent_d[i] = pop ? ent_q[i+1] : ent_q[i];
    for (int i = 0; i < BUF_DEPTH; i++)
      if (push && widx == CNT_W'(i))
        ent_d[i] = '{pc: bus.in_pc, instr: bus.in_instr, ctrl: dec_ctrl, ri: dec_ri, ds: ds_q == DS_SLOT};
    count_d = bus.flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    in_ready_d = count_d < CNT_W'(BUF_DEPTH);
    ds_d = bus.flush ? DS_NORMAL : !push ? ds_q : dec_cti ? DS_SLOT : DS_NORMAL;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      ent_q <= ent_d;
      count_q <= count_d;
      in_ready_q <= in_ready_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ds_q <= DS_NORMAL;
    else ds_q <= ds_d;
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = count_q != '0;
  assign bus.out_pc = ent_q[0].pc;
  assign bus.out_instr = ent_q[0].instr;
  assign bus.out_ctrl = ent_q[0].ctrl;
  assign bus.out_ri = ent_q[0].ri;
  assign bus.out_in_ds = ent_q[0].ds;
endmodule

// File: tb/tb_id_decode_pipe.sv
// tb_id_decode_pipe: directed and random stimulus for id_decode_pipe, checked against a
// field-level decode model and an expected-entry queue.
module tb_id_decode_pipe;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  id_decode_pipe_if #(.PC_W(32), .ALUOP_W(5)) bus ();
  id_decode_pipe #(.ALUOP_W(5), .PC_W(32), .BUF_DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [16:0] ctrl;
    logic ri;
    logic ds;
    logic cti;
  } exp_t;
  exp_t q[$];
  logic in_slot = 1'b0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t ref_decode(logic [31:0] ins);
    logic [5:0] op = ins[31:26];
    logic [5:0] fn = ins[5:0];
    logic [4:0] rt = ins[20:16];
    logic rw = 0, rd = 0, as = 0, br = 0, mw = 0, mr = 0, j = 0, jl = 0, jr = 0, bal = 0, jalr = 0, me = 0;
    logic [4:0] alu = 0;
    exp_t e;
    e.ri = 0;
    if (op == 0) begin
      if (fn == 8) jr = 1;
      else if (fn == 9) begin rw = 1; jalr = 1; end
      else if (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43}) begin rw = 1; rd = 1; alu = 1; end
      else e.ri = 1;
    end else if (op == 1) begin
      if (rt inside {0, 1}) br = 1;
      else if (rt inside {16, 17}) begin br = 1; rw = 1; bal = 1; end
      else e.ri = 1;
    end
    else if (op == 2) j = 1;
    else if (op == 3) begin rw = 1; jl = 1; end
    else if (op inside {[4:7]}) br = 1;
    else if (op inside {[8:15]}) begin rw = 1; as = 1; alu = 5'(op - 6); end
    else if (op inside {32, 33, 35, 36, 37}) begin rw = 1; as = 1; mr = 1; me = 1; alu = 3; end
    else if (op inside {40, 41, 43}) begin as = 1; mw = 1; me = 1; alu = 3; end
    else e.ri = 1;
    e.ctrl = {rw, rd, as, br, mw, mr, j, jl, jr, bal, jalr, alu, me};
    e.cti = br | j | jl | jr | jalr | bal;
    e.instr = ins;
    e.pc = 0;
    e.ds = 0;
    return e;
  endfunction
  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [12] = '{6'd0, 6'd0, 6'd1, 6'd1, 6'd2, 6'd3, 6'd4, 6'd7, 6'd9, 6'd15, 6'd35, 6'd43};
    logic [31:0] w = $urandom;
    if ($urandom_range(0, 4) != 0) w[31:26] = ops[$urandom_range(0, 11)];
    if (w[31:26] == 1 && $urandom_range(0, 2) != 0) w[20:16] = {1'($urandom_range(0, 1)), 3'b000, 1'($urandom_range(0, 1))};
    if (w[31:26] == 0 && $urandom_range(0, 2) != 0) w[5:0] = 6'($urandom_range(0, 9));
    return w;
  endfunction
  task automatic check_outputs();
    chk("out_valid", bus.out_valid, q.size() != 0);
    chk("in_ready", bus.in_ready, q.size() < DEPTH);
    if (q.size() != 0) begin
      chk("out_pc", bus.out_pc, q[0].pc);
      chk("out_instr", bus.out_instr, q[0].instr);
      chk("out_ctrl", bus.out_ctrl, q[0].ctrl);
      chk("out_ri", bus.out_ri, q[0].ri);
      chk("out_in_ds", bus.out_in_ds, q[0].ds);
    end
  endtask
  // One clock: check the current outputs, drive the inputs, advance the model, land on the next negedge.
  task automatic cycle(bit v, logic [31:0] ins, logic [31:0] pc, bit rdy, bit fl);
    exp_t e;
    bit acc, pop;
    check_outputs();
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc = pc;
    bus.out_ready = rdy;
    bus.flush = fl;
    acc = v && q.size() < DEPTH && !fl;
    pop = q.size() != 0 && rdy;
    if (fl) begin
      q.delete();
      in_slot = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        e = ref_decode(ins);
        e.pc = pc;
        e.ds = in_slot;
        in_slot = e.cti;
        q.push_back(e);
      end
    end
    @(negedge clk);
  endtask
  initial begin
    bus.flush = 0;
    bus.in_valid = 0;
    bus.in_instr = 0;
    bus.in_pc = 0;
    bus.out_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_ctrl", bus.out_ctrl, 0);
    chk("rst_pc", bus.out_pc, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_ready", bus.in_ready, 1);
    cycle(1, 32'h24010005, 32'h100, 1, 0);
    chk("addiu_valid", bus.out_valid, 1);
    chk("addiu_ctrl", bus.out_ctrl, 17'h14006);
    chk("addiu_ri", bus.out_ri, 0);
    chk("addiu_ds", bus.out_in_ds, 0);
    cycle(1, 32'h10000003, 32'h104, 1, 0);
    chk("beq_ctrl", bus.out_ctrl, 17'h02000);
    chk("beq_ds", bus.out_in_ds, 0);
    cycle(1, 32'h00000000, 32'h108, 1, 0);
    chk("nop_ctrl", bus.out_ctrl, 17'h18002);
    chk("nop_ds", bus.out_in_ds, 1);
    cycle(1, 32'hFC000000, 32'h10c, 1, 0);
    chk("ill_ri", bus.out_ri, 1);
    chk("ill_ctrl", bus.out_ctrl, 0);
    cycle(1, 32'h041F0000, 32'h110, 1, 0);
    chk("regimm_ri", bus.out_ri, 1);
    chk("regimm_ctrl", bus.out_ctrl, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h8C220004, 32'h200, 0, 0);
    cycle(1, 32'hAC220008, 32'h204, 0, 0);
    chk("full_ready", bus.in_ready, 0);
    chk("lw_ctrl", bus.out_ctrl, 17'h14807);
    cycle(1, 32'h24010005, 32'h208, 1, 0);
    chk("sw_ctrl", bus.out_ctrl, 17'h05007);
    chk("sw_pc", bus.out_pc, 32'h204);
    cycle(1, 32'h24010005, 32'h208, 1, 0);
    chk("addiu2_ctrl", bus.out_ctrl, 17'h14006);
    chk("addiu2_pc", bus.out_pc, 32'h208);
    cycle(0, 0, 0, 1, 0);
    cycle(1, 32'h24010005, 32'h300, 0, 0);
    cycle(1, 32'h10000003, 32'h304, 0, 0);
    cycle(1, 32'h24010005, 32'h308, 0, 1);
    chk("flush_valid", bus.out_valid, 0);
    chk("flush_ready", bus.in_ready, 1);
    cycle(1, 32'h24010005, 32'h30c, 0, 0);
    chk("post_flush_ds", bus.out_in_ds, 0);
    chk("post_flush_pc", bus.out_pc, 32'h30c);
    cycle(1, 32'h10000003, 32'h310, 1, 1);
    chk("flush_drop", bus.out_valid, 0);
    for (int n = 0; n < 3000; n++)
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0);
    cycle(1, 32'h24010005, 32'h500, 0, 0);
    cycle(1, 32'h8C220004, 32'h504, 0, 0);
    #2 rst = 1;
    #1;
    chk("arst_valid", bus.out_valid, 0);
    chk("arst_ctrl", bus.out_ctrl, 0);
    chk("arst_pc", bus.out_pc, 0);
    chk("arst_instr", bus.out_instr, 0);
    chk("arst_ds", bus.out_in_ds, 0);
    q.delete();
    in_slot = 0;
    bus.in_valid = 0;
    @(negedge clk);
    #2 rst = 0;
    @(negedge clk);
    chk("arst_ready", bus.in_ready, 1);
    cycle(1, 32'h24010005, 32'h600, 1, 0);
    chk("arst_addiu", bus.out_ctrl, 17'h14006);
    chk("arst_addiu_ds", bus.out_in_ds, 0);
    cycle(0, 0, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
